stage_mem: RTL and testbench

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem_pkg.sv | 29 ++
 rtl/load_align.sv | 30 +++
 rtl/stage_mem.sv | 174 +++++++++++++++++
 tb/tb_stage_mem.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared encodings for the MEM stage: funct3 access sizes, writeback selects,
// FSM states and the misalignment helper.
package stage_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // funct3[1:0] carries the access size for both loads and stores
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a read word and extends it.
module load_align
    import stage_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: data-memory handshake with wait-state stall, store lane
// steering, load alignment and the MEM->WB register. MISALIGN_TRAP_EN enables
// trapping of misaligned halfword/word accesses.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_res_fromEX,
    input  logic [XLEN-1:0] rs2_fromEX,
    input  logic [XLEN-1:0] pc4_fromEX,
    input  logic [4:0]      rd_idx_fromEX,
    input  logic            reg_wr_fromEX,
    input  logic            mem_rd_fromEX,
    input  logic            mem_wr_fromEX,
    input  logic [2:0]      funct3_fromEX,
    input  logic [1:0]      wb_sel_fromEX,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [3:0]      dm_wstrb,
    output logic [XLEN-1:0] dm_wdata,
    input  logic            dm_ack,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            stall_mem,
    output logic [XLEN-1:0] rd_fwd_toEX,
    output logic [4:0]      rd_idx_toWB,
    output logic            reg_wr_toWB,
    output logic [XLEN-1:0] wb_data_toWB,
    output logic            misalign_trap
);

    mem_state_e      r_state;
    logic [XLEN-1:0] r_addr;
    logic            r_we;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd_idx;
    logic            r_reg_wr;
    logic [XLEN-1:0] r_wb_data;
    logic            r_trap;

    logic            w_access;
    logic            w_store;
    logic            w_mis;
    logic            w_go;
    logic [XLEN-1:0] w_addr;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_wb_data;
    logic            w_stall;

    assign w_access = mem_rd_fromEX | mem_wr_fromEX;
    assign w_store  = mem_wr_fromEX;
    assign w_addr   = {alu_res_fromEX[XLEN-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign w_mis = w_access & is_misaligned(funct3_fromEX, alu_res_fromEX[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    assign w_go = w_access & ~w_mis;

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = rs2_fromEX;
        case (funct3_fromEX[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << alu_res_fromEX[1:0];
                w_wdata = {(XLEN/8){rs2_fromEX[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << {alu_res_fromEX[1], 1'b0};
                w_wdata = {(XLEN/16){rs2_fromEX[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = rs2_fromEX;
            end
        endcase
    end

    // WAIT drives the captured request so the bus stays stable until ack
    always_comb begin
        dm_req   = 1'b0;
        dm_we    = w_store;
        dm_addr  = w_addr;
        dm_wstrb = w_store ? w_wstrb : 4'b0000;
        dm_wdata = w_wdata;
        w_stall  = 1'b0;
        if (!rst) begin
            if (r_state == ST_WAIT) begin
                dm_req   = 1'b1;
                dm_we    = r_we;
                dm_addr  = r_addr;
                dm_wstrb = r_wstrb;
                dm_wdata = r_wdata;
                w_stall  = ~dm_ack;
            end else if (w_go) begin
                dm_req  = 1'b1;
                w_stall = ~dm_ack;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_go && !dm_ack) begin
                    r_state <= ST_WAIT;
                    r_addr  <= w_addr;
                    r_we    <= w_store;
                    r_wstrb <= w_store ? w_wstrb : 4'b0000;
                    r_wdata <= w_wdata;
                end
                ST_WAIT: if (dm_ack) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_funct3 (funct3_fromEX),
        .i_off    (alu_res_fromEX[1:0]),
        .i_rdata  (dm_rdata),
        .o_data   (w_load_data)
    );

    always_comb begin
        case (wb_sel_fromEX)
            WB_MEM:  w_wb_data = w_load_data;
            WB_PC4:  w_wb_data = pc4_fromEX;
            default: w_wb_data = alu_res_fromEX;
        endcase
    end

    // Load data only exists at the end of MEM, so it is never a forward source
    assign rd_fwd_toEX = (wb_sel_fromEX == WB_PC4) ? pc4_fromEX : alu_res_fromEX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_idx  <= 5'd0;
            r_reg_wr  <= 1'b0;
            r_wb_data <= '0;
            r_trap    <= 1'b0;
        end else begin
            r_trap <= w_mis;
            if (w_stall) begin
                r_reg_wr <= 1'b0;
            end else begin
                r_rd_idx  <= rd_idx_fromEX;
                r_reg_wr  <= reg_wr_fromEX & ~w_mis;
                r_wb_data <= w_wb_data;
            end
        end
    end

    assign stall_mem     = w_stall;
    assign rd_idx_toWB   = r_rd_idx;
    assign reg_wr_toWB   = r_reg_wr;
    assign wb_data_toWB  = r_wb_data;
    assign misalign_trap = r_trap;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: stimulus pushes expected WB writes into a
// queue, a monitor pops and compares whenever reg_wr_toWB is seen.
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res_fromEX, rs2_fromEX, pc4_fromEX;
    logic [4:0]  rd_idx_fromEX;
    logic        reg_wr_fromEX, mem_rd_fromEX, mem_wr_fromEX;
    logic [2:0]  funct3_fromEX;
    logic [1:0]  wb_sel_fromEX;
    logic        dm_req, dm_we, dm_ack, stall_mem;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, rd_fwd_toEX, wb_data_toWB;
    logic [3:0]  dm_wstrb;
    logic [4:0]  rd_idx_toWB;
    logic        reg_wr_toWB, misalign_trap;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];

    stage_mem #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_res_fromEX(alu_res_fromEX), .rs2_fromEX(rs2_fromEX), .pc4_fromEX(pc4_fromEX),
        .rd_idx_fromEX(rd_idx_fromEX), .reg_wr_fromEX(reg_wr_fromEX),
        .mem_rd_fromEX(mem_rd_fromEX), .mem_wr_fromEX(mem_wr_fromEX),
        .funct3_fromEX(funct3_fromEX), .wb_sel_fromEX(wb_sel_fromEX),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_mem(stall_mem), .rd_fwd_toEX(rd_fwd_toEX), .rd_idx_toWB(rd_idx_toWB),
        .reg_wr_toWB(reg_wr_toWB), .wb_data_toWB(wb_data_toWB), .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] pc4,
                          input logic [4:0] rdi, input logic rw);
        mem_rd_fromEX  = rd;
        mem_wr_fromEX  = wr;
        funct3_fromEX  = f3;
        wb_sel_fromEX  = sel;
        alu_res_fromEX = alu;
        rs2_fromEX     = rs2;
        pc4_fromEX     = pc4;
        rd_idx_fromEX  = rdi;
        reg_wr_fromEX  = rw;
    endtask

    task automatic bubble();
        set_op(1'b0, 1'b0, 3'b000, WB_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every WB write must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && reg_wr_toWB) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_unexpected: got write rd=%0d data=%h, expected none",
                         rd_idx_toWB, wb_data_toWB);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wb_rd", {27'd0, rd_idx_toWB}, {27'd0, e[36:32]});
                chk("wb_data", wb_data_toWB, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bubble();
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        repeat (2) step();
        chk("rst_reg_wr", {31'd0, reg_wr_toWB}, 32'd0);
        chk("rst_wb_data", wb_data_toWB, 32'd0);
        chk("rst_rd_idx", {27'd0, rd_idx_toWB}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LW 0x100, zero wait states
        step();
        set_op(1'b1, 1'b0, F3_W, WB_MEM, 32'h100, 32'h0, 32'h104, 5'd5, 1'b1);
        dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
        exp_q.push_back({5'd5, 32'hCAFEF00D});
        @(negedge clk);
        chk("lw_stall", {31'd0, stall_mem}, 32'd0);
        chk("lw_req", {31'd0, dm_req}, 32'd1);
        chk("lw_addr", dm_addr, 32'h100);
        chk("lw_fwd_no_load", rd_fwd_toEX, 32'h100);
        step();
        bubble(); dm_ack = 1'b0;
        @(negedge clk);
        chk("lw_wb_valid", {31'd0, reg_wr_toWB}, 32'd1);

        // LB 0x103 with three wait states; EX inputs wobble to prove capture
        step();
        set_op(1'b1, 1'b0, F3_B, WB_MEM, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1);
        dm_ack = 1'b0; dm_rdata = 32'h80FFFFFF;
        @(negedge clk);
        chk("lb_stall0", {31'd0, stall_mem}, 32'd1);
        chk("lb_addr0", dm_addr, 32'h100);
        for (int i = 1; i < 3; i++) begin
            step();
            alu_res_fromEX = 32'h7F3;
            @(negedge clk);
            chk("lb_stall_wait", {31'd0, stall_mem}, 32'd1);
            chk("lb_req_wait", {31'd0, dm_req}, 32'd1);
            chk("lb_addr_wait", dm_addr, 32'h100);
        end
        step();
        dm_ack = 1'b1;
        exp_q.push_back({5'd7, 32'hFFFFFF80});
        @(negedge clk);
        chk("lb_stall_ack", {31'd0, stall_mem}, 32'd0);
        chk("lb_addr_ack", dm_addr, 32'h100);
        step();
        bubble(); dm_ack = 1'b0;

        // Stores
        step();
        set_op(1'b0, 1'b1, F3_H, WB_ALU, 32'h206, 32'h1234ABCD, 32'h0, 5'd0, 1'b0);
        dm_ack = 1'b1;
        @(negedge clk);
        chk("sh_strb", {28'd0, dm_wstrb}, 32'hC);
        chk("sh_wdata", dm_wdata, 32'hABCDABCD);
        chk("sh_addr", dm_addr, 32'h204);
        chk("sh_we", {31'd0, dm_we}, 32'd1);
        chk("sh_stall", {31'd0, stall_mem}, 32'd0);
        step();
        set_op(1'b0, 1'b1, F3_B, WB_ALU, 32'h101, 32'h000000EE, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        chk("sb_strb", {28'd0, dm_wstrb}, 32'h2);
        chk("sb_wdata", dm_wdata, 32'hEEEEEEEE);
        step();
        set_op(1'b1, 1'b1, F3_W, WB_ALU, 32'h200, 32'h11223344, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        chk("rdwr_we", {31'd0, dm_we}, 32'd1);
        chk("sw_strb", {28'd0, dm_wstrb}, 32'hF);
        chk("sw_wdata", dm_wdata, 32'h11223344);

        // Sign/zero-extended loads, back to back
        step();
        set_op(1'b1, 1'b0, F3_H, WB_MEM, 32'h102, 32'h0, 32'h0, 5'd8, 1'b1);
        dm_rdata = 32'h80011234;
        exp_q.push_back({5'd8, 32'hFFFF8001});
        step();
        set_op(1'b1, 1'b0, F3_HU, WB_MEM, 32'h102, 32'h0, 32'h0, 5'd9, 1'b1);
        exp_q.push_back({5'd9, 32'h00008001});
        step();
        set_op(1'b1, 1'b0, F3_BU, WB_MEM, 32'h101, 32'h0, 32'h0, 5'd10, 1'b1);
        dm_rdata = 32'h0000A500;
        exp_q.push_back({5'd10, 32'h000000A5});

        // JAL-style PC4 writeback and plain ALU writeback
        step();
        set_op(1'b0, 1'b0, F3_W, WB_PC4, 32'h1000, 32'h0, 32'h44, 5'd1, 1'b1);
        dm_ack = 1'b0;
        exp_q.push_back({5'd1, 32'h44});
        @(negedge clk);
        chk("jal_fwd", rd_fwd_toEX, 32'h44);
        chk("jal_req", {31'd0, dm_req}, 32'd0);
        step();
        set_op(1'b0, 1'b0, F3_W, WB_ALU, 32'hDEADBEEF, 32'h0, 32'h8, 5'd2, 1'b1);
        exp_q.push_back({5'd2, 32'hDEADBEEF});
        @(negedge clk);
        chk("alu_fwd", rd_fwd_toEX, 32'hDEADBEEF);

        // Reset while waiting abandons the access; stray ack afterwards
        step();
        set_op(1'b1, 1'b0, F3_W, WB_MEM, 32'h300, 32'h0, 32'h0, 5'd3, 1'b1);
        step();
        chk("wait_req", {31'd0, dm_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_wait_req", {31'd0, dm_req}, 32'd0);
        chk("rst_wait_stall", {31'd0, stall_mem}, 32'd0);
        bubble();
        @(negedge clk);
        rst = 1'b0;
        step();
        dm_ack = 1'b1;
        @(negedge clk);
        chk("stray_ack_req", {31'd0, dm_req}, 32'd0);
        chk("stray_ack_stall", {31'd0, stall_mem}, 32'd0);
        step();
        dm_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_no_wb", {31'd0, reg_wr_toWB}, 32'd0);

        // Misaligned LW 0x102
        step();
        set_op(1'b1, 1'b0, F3_W, WB_MEM, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1);
        dm_ack = 1'b1; dm_rdata = 32'h55667788;
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        chk("mis_req", {31'd0, dm_req}, 32'd0);
        chk("mis_stall", {31'd0, stall_mem}, 32'd0);
        step();
        bubble(); dm_ack = 1'b0;
        @(negedge clk);
        chk("mis_trap", {31'd0, misalign_trap}, 32'd1);
        chk("mis_no_wb", {31'd0, reg_wr_toWB}, 32'd0);
        step();
        @(negedge clk);
        chk("mis_trap_off", {31'd0, misalign_trap}, 32'd0);
`else
        exp_q.push_back({5'd4, 32'h55667788});
        @(negedge clk);
        chk("mis_req", {31'd0, dm_req}, 32'd1);
        chk("mis_addr", dm_addr, 32'h100);
        step();
        bubble(); dm_ack = 1'b0;
        @(negedge clk);
        chk("mis_trap", {31'd0, misalign_trap}, 32'd0);
`endif

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
